// File: rtl/data_pkg.sv
// Shared constants for the SD host data path (data_control, data_send, data_fifo).
package data_pkg;

  localparam int FIFO_data_size         = 32;
  localparam int Blocks_size_to_process = 512;
  localparam int Register_size          = 32;

  localparam int FIFO_addr_size = 4;
  localparam int FIFO_depth     = 1 << FIFO_addr_size;
  localparam int Almost_margin  = 2;

endpackage

// File: rtl/data_fifo_mem.sv
// Storage array for data_fifo: one write port and one registered read port.
// Only the read register is reset; the array itself keeps whatever it held.
module data_fifo_mem
  import data_pkg::*;
#(
  parameter int DATA_W = FIFO_data_size,
  parameter int ADDR_W = FIFO_addr_size
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data
);

  logic [DATA_W-1:0] mem [1 << ADDR_W];

  // Write port: store the pushed word at the write address.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  // Read port: capture the addressed word on a pop, otherwise hold the last one.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_data <= '0;
    end else if (rd_en) begin
      rd_data <= mem[rd_addr];
    end
  end

endmodule

// File: rtl/data_fifo.sv
// Word FIFO between the host bus interface and data_send. Occupancy is kept in
// its own counter; status flags decode that counter, so they only change on an edge.
module data_fifo #(
  parameter int FIFO_data_size = data_pkg::FIFO_data_size,
  parameter int FIFO_addr_size = data_pkg::FIFO_addr_size,
  parameter int Almost_margin  = data_pkg::Almost_margin
) (
  input  logic                      iClock,
  input  logic                      iReset,
  input  logic                      iFlush,
  input  logic                      iWrite_enable,
  input  logic [FIFO_data_size-1:0] iData_in,
  input  logic                      iRead_enable,
  output logic [FIFO_data_size-1:0] oData_out,
  output logic                      oData_valid,
  output logic                      oFull,
  output logic                      oEmpty,
  output logic                      oAlmost_full,
  output logic                      oAlmost_empty,
  output logic [FIFO_addr_size:0]   oCount,
  output logic                      oFIFO_ok
);

  localparam int CW    = FIFO_addr_size + 1;
  localparam int DEPTH = 1 << FIFO_addr_size;

  localparam logic [CW-1:0]             CNT_DEPTH  = CW'(DEPTH);
  localparam logic [CW-1:0]             CNT_AFULL  = CW'(DEPTH - Almost_margin);
  localparam logic [CW-1:0]             CNT_AEMPTY = CW'(Almost_margin);
  localparam logic [CW-1:0]             CNT_ONE    = CW'(1);
  localparam logic [FIFO_addr_size-1:0] PTR_ONE    = FIFO_addr_size'(1);

  logic [FIFO_addr_size-1:0] wp;
  logic [FIFO_addr_size-1:0] rp;
  logic [CW-1:0]             count;
  logic                      data_valid;
  logic                      overflow_err;
  logic                      underflow_err;
  logic                      full;
  logic                      empty;
  logic                      active;
  logic                      push_ok;
  logic                      pop_ok;

  // Accept/reject decisions; a pop frees a slot so a full FIFO can still take a push.
  always_comb begin
    full    = (count == CNT_DEPTH);
    empty   = (count == '0);
    active  = iReset && !iFlush;
    pop_ok  = active && iRead_enable && !empty;
    push_ok = active && iWrite_enable && (!full || pop_ok);
  end

  // Pointers, occupancy and the pop-valid pulse; reset beats flush beats traffic.
  always_ff @(posedge iClock) begin
    if (!iReset) begin
      wp         <= '0;
      rp         <= '0;
      count      <= '0;
      data_valid <= 1'b0;
    end else if (iFlush) begin
      wp         <= '0;
      rp         <= '0;
      count      <= '0;
      data_valid <= 1'b0;
    end else begin
      if (push_ok) wp <= wp + PTR_ONE;
      if (pop_ok)  rp <= rp + PTR_ONE;
      case ({push_ok, pop_ok})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
      data_valid <= pop_ok;
    end
  end

  // Sticky error flags: any rejected request latches until the next reset.
  always_ff @(posedge iClock) begin
    if (!iReset) begin
      overflow_err  <= 1'b0;
      underflow_err <= 1'b0;
    end else if (!iFlush) begin
      if (iWrite_enable && !push_ok) overflow_err  <= 1'b1;
      if (iRead_enable && !pop_ok)   underflow_err <= 1'b1;
    end
  end

  data_fifo_mem #(
    .DATA_W (FIFO_data_size),
    .ADDR_W (FIFO_addr_size)
  ) u_mem (
    .clk     (iClock),
    .rst_n   (iReset),
    .wr_en   (push_ok),
    .wr_addr (wp),
    .wr_data (iData_in),
    .rd_en   (pop_ok),
    .rd_addr (rp),
    .rd_data (oData_out)
  );

  assign oData_valid   = data_valid;
  assign oFull         = full;
  assign oEmpty        = empty;
  assign oAlmost_full  = (count >= CNT_AFULL);
  assign oAlmost_empty = (count <= CNT_AEMPTY);
  assign oCount        = count;
  assign oFIFO_ok      = !(overflow_err || underflow_err);

endmodule

// File: doc/data_fifo.md
# data_fifo

Word buffer between the host bus interface and `data_send` in the SD host data path. Write transfers: the host fills it and `data_send` drains it through `oRead_enable`/`iData_from_FIFO`. Read transfers: `data_send` fills it through `oWrite_enable`/`oData_to_FIFO` and the host drains it. It reports occupancy, almost-full/almost-empty and a sticky health flag that `data_control` samples as `iFIFO_ok`.

## Interface
- `FIFO_data_size`, 32: word width in bits.
- `FIFO_addr_size`, 4: log2 of depth; depth = 16.
- `Almost_margin`, 2: words from full/empty at which the almost flags assert.
- `iClock` in 1: single clock; all logic on rising edge.
- `iReset` in 1: synchronous, active-low; sampled on `iClock`.
- `iFlush` in 1: synchronous clear of pointers and count.
- `iWrite_enable` in 1: push request.
- `iData_in` in `FIFO_data_size`: push data.
- `iRead_enable` in 1: pop request.
- `oData_out` out `FIFO_data_size`: registered popped word.
- `oData_valid` out 1: one-cycle pulse when `oData_out` holds a newly popped word.
- `oFull` out 1: count == depth.
- `oEmpty` out 1: count == 0.
- `oAlmost_full` out 1: count >= depth − `Almost_margin`.
- `oAlmost_empty` out 1: count <= `Almost_margin`.
- `oCount` out `FIFO_addr_size+1`: current occupancy, 0..depth.
- `oFIFO_ok` out 1: low once an overflow or underflow has occurred (sticky).

## Operation
- Storage: circular buffer, write pointer `wp`, read pointer `rp`, both `FIFO_addr_size` bits, natural wrap from depth−1 to 0. Occupancy comes from a separate `FIFO_addr_size+1`-bit counter, not from pointer difference.
- Push accepted = `iWrite_enable` and (not full, or pop accepted in the same cycle). Accepted push writes `mem[wp]` and increments `wp`.
- Pop accepted = `iRead_enable` and not empty. Accepted pop registers `mem[rp]` into `oData_out`, pulses `oData_valid` and increments `rp`.
- There is no fall-through. A push and a pop in the same cycle on an empty FIFO:
  - the pop is rejected as an underflow;
  - the push is accepted;
  - count becomes 1.
- Push and pop both accepted: count unchanged. A full FIFO stays full and an empty one stays empty; data order is preserved.
- Rejected push (full, no pop): data is discarded, and the overflow error sets.
- Rejected pop (empty): `oData_out` holds its value, `oData_valid` stays 0, and the underflow error sets.
- `oFIFO_ok` = not(overflow_err or underflow_err). The error flags clear only on reset.
- `iFlush`:
  - zeroes `wp`, `rp` and count;
  - overrides any push or pop in the same cycle (both ignored, no error set);
  - leaves `oData_out` and the error flags unchanged;
  - forces `oData_valid` to 0.
- Memory contents are not reset.

## Timing
- Reset values, asserted on the first edge with `iReset`=0:
  - `oData_out`=0, `oData_valid`=0, `oCount`=0
  - `oEmpty`=1, `oFull`=0
  - `oAlmost_empty`=1, `oAlmost_full`=0
  - `oFIFO_ok`=1
- Reset mid-transfer discards all contents.
- Pop latency: 1 cycle. A pop requested at edge N shows its word on `oData_out` with `oData_valid`=1 in the cycle after edge N.
- A word pushed at edge N can be popped at edge N+1 at the earliest.
- Status outputs (`oFull`, `oEmpty`, almost flags, `oCount`, `oFIFO_ok`) are registered. They reflect the state after the most recent edge; no combinational path from the request inputs.
- Reset has priority over `iFlush`, which has priority over push and pop.

## Structure
- Shared package `data_pkg`:
  - `FIFO_data_size`, `Blocks_size_to_process`, `Register_size` constants, shared with `data_control` and `data_send`;
  - FIFO depth constants.
- Sub-module `data_fifo_mem`:
  - one write port, one synchronous read port;
  - register array, `FIFO_data_size` × 2^`FIFO_addr_size`;
  - the pointers, counter, flags and errors live in `data_fifo`.

## Test plan
- Reset, then push 0x00000001..0x00000010 on 16 consecutive cycles, then pop 16 -> pop output is:
  - same order, one word per cycle after 1-cycle latency;
  - `oFull`=1 after the 16th push;
  - `oEmpty`=1 after the 16th pop;
  - `oFIFO_ok`=1 throughout.
- Fill to 16, push 0xDEADBEEF with no pop -> word dropped, `oCount`=16, `oFIFO_ok`=0 next cycle; it stays 0 until reset.
- Empty FIFO, push 0xA5A5A5A5 and pop in the same cycle -> `oCount`=1, `oData_valid`=0, `oFIFO_ok`=0; the next pop returns 0xA5A5A5A5.
- Fill to 16, then push+pop every cycle for 40 cycles -> `oCount` stays 16, no error, pointers wrap, outputs are in FIFO order.
- Count sweep 0..16 -> `oAlmost_empty` for count <= 2, `oAlmost_full` for count >= 14.
- Load 5 words, assert `iFlush` together with a push -> `oCount`=0, `oEmpty`=1, `oData_out` unchanged, error flags unchanged. Repeat the load, then assert `iReset`=0 for 1 cycle -> all reset values restored.
